// File: rtl/pim_shift_pkg.sv
// Shared definitions for the PIM left-shift sequencer family.
//   state_e      : controller states (IDLE, RUN, DONE)
//   SHIFT_LOGIC  : mode encoding for logical left shift (zero fill)
//   SHIFT_ROT    : mode encoding for rotate left
//   cntWidth()   : stage-counter width for a given number of stages
//   CNT_W        : stage-counter width for the default five-stage build
package pim_shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic SHIFT_LOGIC = 1'b0;
    localparam logic SHIFT_ROT   = 1'b1;

    // The counter must be able to index every bit of the shift amount.
    // It is never narrower than one bit, even for a single-stage build.
    function automatic int cntWidth(input int sw);
        return (sw <= 1) ? 1 : $clog2(sw);
    endfunction

    localparam int DEFAULT_SHIFT_WIDTH = 5;
    localparam int CNT_W               = cntWidth(DEFAULT_SHIFT_WIDTH);

endpackage

// File: rtl/shift_stage_l.sv
// One conditional log2 stage of a left shifter / left rotator.
// When enabled, data is moved left by 2^idx_i positions.
//   data_i : operand
//   en_i   : apply this stage (the matching bit of the shift amount)
//   idx_i  : stage index; the stage distance is 2^idx_i
//   rot_i  : SHIFT_LOGIC = zero fill, SHIFT_ROT = rotate
//   data_o : stage result (equal to data_i when en_i is low)
module shift_stage_l
    import pim_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             rot_i,
    output logic [WIDTH-1:0] data_o
);

    logic [31:0] stepAmt;
    logic [31:0] rotAmt;

    // A logical stage whose distance reaches WIDTH clears the word.
    // A rotate stage only moves by the distance modulo WIDTH. A modulo
    // result of zero also works here, because shifting right by WIDTH
    // yields zero and the OR leaves the operand unchanged.
    always_comb begin
        stepAmt = 32'd1 << idx_i;
        rotAmt  = stepAmt % 32'(WIDTH);
        data_o  = data_i;
        if (en_i) begin
            if (rot_i == SHIFT_ROT) begin
                data_o = (data_i << rotAmt) | (data_i >> (32'(WIDTH) - rotAmt));
            end else if (stepAmt >= 32'(WIDTH)) begin
                data_o = '0;
            end else begin
                data_o = data_i << stepAmt;
            end
        end
    end

endmodule

// File: rtl/shift_l_seq_ctrl.sv
// Stage-serial left shifter / rotator with a valid/ready handshake on each side.
// Each RUN cycle applies one log2 stage, so latency is fixed at SHIFT_WIDTH cycles.
//   clk, rst_n          : clock; synchronous active-low reset
//   in_valid / in_ready : request handshake
//   in_a, in_b, in_rot  : operand, shift amount, and mode (0 = logical, 1 = rotate)
//   out_valid/out_ready : result handshake
//   out_y               : result (meaningful only while out_valid is high)
//   busy                : high while in RUN or DONE
module shift_l_seq_ctrl
    import pim_shift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHIFT_WIDTH = DEFAULT_SHIFT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [SHIFT_WIDTH-1:0] in_b,
    input  logic                   in_rot,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_y,
    output logic                   busy
);

    localparam int CntBits = cntWidth(SHIFT_WIDTH);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [SHIFT_WIDTH-1:0] amt_q, amt_d;
    logic                   rot_q, rot_d;
    logic [CntBits-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]       stageOut;
    logic                   accept;

    // A new request can be taken in IDLE. It can also be taken in DONE on
    // the same edge that the current result is consumed.
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_y     = acc_q;
    assign busy      = (state_q != IDLE);

    // One shared stage. The counter selects both the stage distance and
    // the shift-amount bit that decides whether this stage is applied.
    shift_stage_l #(
        .WIDTH (WIDTH),
        .IDX_W (CntBits)
    ) u_stage (
        .data_i (acc_q),
        .en_i   (amt_q[cnt_q]),
        .idx_i  (cnt_q),
        .rot_i  (rot_q),
        .data_o (stageOut)
    );

    // Next-state logic. RUN always takes SHIFT_WIDTH cycles; there is no
    // early exit. Accepting a request overrides the per-state choice,
    // which is how the back-to-back hand-off from DONE goes straight to RUN.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: ;
            RUN: begin
                acc_d = stageOut;
                cnt_d = cnt_q + CntBits'(1);
                if (cnt_q == CntBits'(SHIFT_WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            acc_d   = in_a;
            amt_d   = in_b;
            rot_d   = in_rot;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    // State registers. Reset clears everything, so an operation caught
    // mid-flight is dropped and never reaches the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            amt_q   <= '0;
            rot_q   <= SHIFT_LOGIC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
